// File: rtl/gpio_ser_pkg.sv
// Shared types and defaults for the GPIO serial deserializer and its word FIFO.
// The optional parity stage is enabled with GPIO_DESER_PARITY_EN.
package gpio_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } deser_state_e;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gpio_word_fifo.sv
// Synchronous read-first word FIFO with wrap-bit pointers; head word is shown
// combinationally from registered state.
module gpio_word_fifo
    import gpio_ser_pkg::*;
#(
    parameter  int W     = DEF_DATA_W,
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW-1:0] level_o
);

    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/gpio_deserialization.sv
// Rebuilds MSB-first words from a strobed serial line and buffers them in a FIFO.
// Define GPIO_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module gpio_deserialization
    import gpio_ser_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PW         = ptr_width(FIFO_DEPTH),
    localparam int CW         = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdi,
    input  logic              sdi_valid,
    input  logic              sync,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [PW-1:0]     level,
    output logic              busy,
    output logic              overflow,
    output logic              parity_err
);

    deser_state_e      state_q, state_d, cur_state;
    logic [CW-1:0]     cnt_q, cnt_d, cur_cnt;
    logic [DATA_W-1:0] sh_q, sh_d, cur_sh, shifted, push_data;
    logic              push_req, perr_d, fifo_full, fifo_empty;
    logic              overflow_q, parity_err_q;

    // sync acts as if the FSM were already in IDLE with cleared registers.
    always_comb begin
        cur_state = sync ? IDLE : state_q;
        cur_cnt   = sync ? '0 : cnt_q;
        cur_sh    = sync ? '0 : sh_q;
        shifted   = {cur_sh[DATA_W-2:0], sdi};
    end

    always_comb begin
        state_d   = cur_state;
        cnt_d     = cur_cnt;
        sh_d      = cur_sh;
        push_req  = 1'b0;
        push_data = shifted;
        perr_d    = 1'b0;
        if (sdi_valid) begin
            case (cur_state)
                IDLE: begin
                    sh_d    = shifted;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sh_d = shifted;
                    if (cur_cnt == CW'(DATA_W - 1)) begin
                        cnt_d = '0;
`ifdef GPIO_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d  = IDLE;
                        push_req = 1'b1;
`endif
                    end else begin
                        cnt_d = cur_cnt + CW'(1);
                    end
                end
`ifdef GPIO_DESER_PARITY_EN
                PARITY: begin
                    push_data = cur_sh;
                    sh_d      = '0;
                    state_d   = IDLE;
                    if (^{cur_sh, sdi} == 1'b0) begin
                        push_req = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            overflow_q   <= push_req && fifo_full && !dout_ready;
            parity_err_q <= perr_d;
        end
    end

    gpio_word_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push_req),
        .wdata_i (push_data),
        .pop_i   (dout_ready),
        .rdata_o (dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign dout_valid = !fifo_empty;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
`ifdef GPIO_DESER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_deserialization.sv
// Scoreboard bench for gpio_deserialization: bit-list reference model feeds an
// expected-word queue; a negedge monitor compares every presented output.
module tb_gpio_deserialization;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;
`ifdef GPIO_DESER_PARITY_EN
  localparam int WORD_BITS = DW + 1;
`else
  localparam int WORD_BITS = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sdi = 1'b0, sdi_valid = 1'b0, sync = 1'b0, dout_ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, busy, overflow, parity_err;
  logic [PW-1:0] level;

  gpio_deserialization #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdi_valid(sdi_valid), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .level(level), .busy(busy), .overflow(overflow), .parity_err(parity_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  bit bits_q[$];
  int m_level = 0;
  bit nxt_ovf = 0, nxt_perr = 0;
  int cur_level = 0;
  bit cur_ovf = 0, cur_perr = 0, cur_busy = 0;
  bit run_mon = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model predicts the effect of the coming edge.
  task automatic drive(input bit v, input bit b, input bit s, input bit r);
    bit pop, ok;
    int word, ones;
    @(posedge clk); #1;
    cur_level = m_level;
    cur_ovf   = nxt_ovf;
    cur_perr  = nxt_perr;
    cur_busy  = (bits_q.size() != 0);
    sdi_valid = v; sdi = b; sync = s; dout_ready = r;
    pop = r && (m_level > 0);
    nxt_ovf = 0; nxt_perr = 0;
    if (s) bits_q.delete();
    if (v) bits_q.push_back(b);
    if (bits_q.size() == WORD_BITS) begin
      word = 0; ones = 0;
      for (int i = 0; i < DW; i++) word = word * 2 + int'(bits_q[i]);
      for (int i = 0; i < WORD_BITS; i++) ones += int'(bits_q[i]);
      ok = (WORD_BITS == DW) || (ones % 2 == 0);
      bits_q.delete();
      if (!ok) nxt_perr = 1;
      else if (m_level == DEPTH && !pop) nxt_ovf = 1;
      else begin
        exp_q.push_back(DW'(word));
        m_level++;
      end
    end
    if (pop) m_level--;
  endtask

  task automatic send_word(input logic [DW-1:0] data, input int gap, input bit rdy,
                           input bit rdy_last, input bit par_flip);
    logic [DW-1:0] d;
    d = data;
    for (int i = DW - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) drive(0, 0, 0, rdy);
`ifdef GPIO_DESER_PARITY_EN
      drive(1, d[i], 0, rdy);
`else
      drive(1, d[i], 0, (i == 0) ? rdy_last : rdy);
`endif
    end
`ifdef GPIO_DESER_PARITY_EN
    drive(1, (^d) ^ par_flip, 0, rdy_last);
`else
    if (par_flip) drive(0, 0, 0, rdy);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (m_level > 0 && n < 50) begin
      drive(0, 0, 0, 1);
      n++;
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("drain_level", m_level, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_parity_err", parity_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    sdi_valid = 0; sdi = 0; sync = 0; dout_ready = 0;
    #1;
    check_reset_outputs();
    exp_q.delete(); bits_q.delete();
    m_level = 0; nxt_ovf = 0; nxt_perr = 0;
    cur_level = 0; cur_ovf = 0; cur_perr = 0; cur_busy = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && run_mon) begin
      chk("level", level, cur_level);
      chk("dout_valid", dout_valid, cur_level > 0);
      chk("busy", busy, cur_busy);
      chk("overflow", overflow, cur_ovf);
      chk("parity_err", parity_err, cur_perr);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          chk("dout", dout, exp_q[0]);
          if (dout_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_mon = 1;

    send_word(8'hA5, 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drain();

    send_word(8'h3C, 2, 0, 0, 0);
    drain();

    repeat (3) drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    repeat (7) drive(1, 1, 0, 0);
`ifdef GPIO_DESER_PARITY_EN
    drive(1, 1, 0, 0);
`endif
    drain();

    for (int w = 1; w <= 5; w++) send_word(DW'(w), 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drain();

    for (int w = 1; w <= 4; w++) send_word(DW'(8'h10 + w), 0, 0, 0, 0);
    send_word(8'h99, 0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drain();

`ifdef GPIO_DESER_PARITY_EN
    send_word(8'hA5, 0, 0, 0, 0);
    send_word(8'hA5, 0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drain();
`endif

    send_word(8'h5A, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    do_reset();
    send_word(8'hFF, 0, 0, 0, 0);
    drain();

    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 40);
    end
    drain();
    chk("exp_q_empty", exp_q.size(), 0);

    run_mon = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_deserialization.md
Name: gpio_deserialization

Overview:
- Downstream partner of the GPIO byte serializer. It receives the serial bit line plus a per-bit strobe and rebuilds DATA_W-bit words, MSB first.
- Completed words are buffered in a small FIFO and presented on a valid/ready parallel interface to the consuming logic.
- It provides realignment through a sync input and reports overflow and (optionally) parity errors.

Parameters:
- DATA_W, 8, word width in bits; must be ≥2.
- FIFO_DEPTH, 4, number of buffered words; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sdi  in  1  serial data bit; sampled only when sdi_valid=1.
- sdi_valid  in  1  bit strobe; one bit is consumed per cycle in which it is high.
- sync  in  1  discard any partial word and realign to bit 0.
- dout  out  DATA_W  FIFO head word.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  partial word in progress (FSM in SHIFT or PARITY).
- overflow  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- parity_err  out  1  one-cycle pulse on a parity mismatch; tied 0 without the macro.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, bit counter=0, shift register=0, FIFO empty, pointers=0. Outputs: dout=0, dout_valid=0, level=0, busy=0, overflow=0, parity_err=0.
- Shifting: on each sdi_valid, shreg <= {shreg[DATA_W-2:0], sdi} and the counter increments. The first received bit is the MSB.
- FSM states:
  - IDLE: counter=0. An sdi_valid moves to SHIFT.
  - SHIFT: counting. The sdi_valid carrying bit DATA_W-1 completes the word → push request; return to IDLE, or go to PARITY if the macro is set.
  - PARITY (macro only): the next sdi_valid is the parity bit → push or drop, then IDLE.
- sync:
  - Asserting sync clears the counter and shifter and forces IDLE.
  - If sdi_valid is high in the same cycle, that bit is taken as bit 0 of a new word (FSM→SHIFT).
  - sync during IDLE has no effect.
  - sync never touches the FIFO.
- Push latency: the word is written on the clock edge that samples its final bit (or the parity bit). dout_valid rises on the next cycle if the FIFO was empty.
- FIFO:
  - Synchronous, read-first.
  - dout shows mem[rd_ptr] combinationally from registered state.
  - Pop on dout_valid && dout_ready.
- Full boundary:
  - Push while full with no pop → word dropped, overflow=1 for one cycle, FIFO unchanged.
  - Push and pop in the same cycle while full → both take effect, level unchanged, no overflow.
- Empty boundary:
  - dout_ready while empty is ignored.
  - A push while empty, with dout_ready high, cannot pop in the same cycle. The word appears next cycle.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- level = wr_ptr − rd_ptr, modulo pointer width.
- A reset asserted mid-word or mid-FIFO discards everything immediately.

Optional Feature:
- GPIO_DESER_PARITY_EN defined:
  - Each word is followed by one even-parity bit.
  - The word is pushed only if XOR(data, parity bit)=0.
  - Otherwise the word is dropped and parity_err pulses for one cycle.
  - Overflow is checked only for words that pass parity.
- Not defined: no PARITY state, the word is pushed after DATA_W bits, and parity_err is constant 0.

Decomposition:
- Package gpio_ser_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the default DATA_W/FIFO_DEPTH localparams;
  - a function for pointer width.
- Sub-module gpio_word_fifo:
  - parameterised sync FIFO with push/pop/full/empty/level;
  - the deserializer instantiates it.

Test Plan:
- Basic word: bits 1,0,1,0,0,1,0,1 on 8 consecutive sdi_valid cycles → dout=0xA5, with dout_valid=1 one cycle after the 8th bit and level=1.
- Gapped strobe: 0x3C sent with sdi_valid high every third cycle → dout=0x3C, busy=1 from the first bit until the last-bit edge.
- Realignment: 3 bits of 1, then sync with sdi_valid=1, sdi=0, then 7 bits 1,1,1,1,1,1,1 → dout=0x7F. No word is formed from the discarded partial.
- Overflow: 5 words 0x01..0x05 with dout_ready=0 → level=4 and overflow pulses once at word 5. Draining then yields 0x01–0x04 in order.
- Full with simultaneous pop: FIFO full, dout_ready=1 in the cycle word 0x99 completes → no overflow, level stays 4, and 0x99 emerges last.
- Parity (macro on): 0xA5 with parity bit 0 → pushed. 0xA5 with parity bit 1 → parity_err pulse, level unchanged.
- Reset mid-word: rst_n=0 after 4 bits → all outputs 0 immediately. A fresh 0xFF afterwards yields 0xFF.
